// File: rtl/mips_wb_stage_buffered.sv
// Writeback stage with a small in-order retire queue between the memory stage
// and the register file / trace consumer. Strobes fire only on the retire cycle.
module mips_wb_stage_buffered #(
    parameter int DATA_W    = 32,
    parameter int OP_W      = 32,
    parameter int RW_BIT    = 15,
    parameter int BE_LSB    = 16,
    parameter int HI_WE_BIT = 20,
    parameter int LO_WE_BIT = 21,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_ready_go,
    output logic              wb_allowin,
    input  logic [OP_W-1:0]   mem_out_op,
    input  logic [4:0]        mem_rf_waddr,
    input  logic [DATA_W-1:0] mem_value,
    input  logic [DATA_W-1:0] mem_hi_value,
    input  logic [DATA_W-1:0] mem_lo_value,
    input  logic [DATA_W-1:0] mem_pc,
    input  logic [DATA_W-1:0] mem_instruction,
    input  logic              trace_ready,
    output logic              wb_valid,
    output logic [3:0]        wb_rf_wen,
    output logic [4:0]        wb_rf_waddr,
    output logic [DATA_W-1:0] wb_rf_wdata,
    output logic              wb_hi_wen,
    output logic [DATA_W-1:0] wb_hi_value,
    output logic              wb_lo_wen,
    output logic [DATA_W-1:0] wb_lo_value,
    output logic [DATA_W-1:0] wb_pc,
    output logic [DATA_W-1:0] wb_instruction,
    output logic [OP_W-1:0]   wb_out_op,
    output logic [CNT_W-1:0]  wb_retire_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [OP_W-1:0]   op_q    [DEPTH];
    logic [4:0]        waddr_q [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] hi_q    [DEPTH];
    logic [DATA_W-1:0] lo_q    [DEPTH];
    logic [DATA_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] inst_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;

    logic       push;
    logic       retire;
    logic [3:0] raw_be;
    logic [3:0] head_be;

    // Valid/ready: an entry moves when its producer offers it and the receiver
    // accepts in the same cycle; allowin may depend combinationally on trace_ready.
    assign wb_valid   = (occupancy != '0);
    assign retire     = wb_valid & trace_ready;
    assign wb_allowin = (occupancy < FULL) | retire;
    assign push       = mem_valid_ready_go & wb_allowin;

    assign wb_out_op      = op_q[rd_ptr];
    assign wb_rf_waddr    = waddr_q[rd_ptr];
    assign wb_rf_wdata    = value_q[rd_ptr];
    assign wb_hi_value    = hi_q[rd_ptr];
    assign wb_lo_value    = lo_q[rd_ptr];
    assign wb_pc          = pc_q[rd_ptr];
    assign wb_instruction = inst_q[rd_ptr];

    // An empty byte-enable field means a legacy full-word write.
    assign raw_be    = wb_out_op[BE_LSB +: 4];
    assign head_be   = (raw_be == 4'b0000) ? 4'b1111 : raw_be;
    assign wb_rf_wen = {4{retire & wb_out_op[RW_BIT] & (wb_rf_waddr != 5'd0)}} & head_be;
    assign wb_hi_wen = retire & wb_out_op[HI_WE_BIT];
    assign wb_lo_wen = retire & wb_out_op[LO_WE_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            wb_retire_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]    <= '0;
                waddr_q[i] <= '0;
                value_q[i] <= '0;
                hi_q[i]    <= '0;
                lo_q[i]    <= '0;
                pc_q[i]    <= '0;
                inst_q[i]  <= '0;
            end
        end else begin
            if (push) begin
                op_q[wr_ptr]    <= mem_out_op;
                waddr_q[wr_ptr] <= mem_rf_waddr;
                value_q[wr_ptr] <= mem_value;
                hi_q[wr_ptr]    <= mem_hi_value;
                lo_q[wr_ptr]    <= mem_lo_value;
                pc_q[wr_ptr]    <= mem_pc;
                inst_q[wr_ptr]  <= mem_instruction;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (retire) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                wb_retire_cnt <= wb_retire_cnt + CNT_W'(1);
            end
            case ({push, retire})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Overflow cannot happen through the allowin handshake; catch it if it ever does.
    assert property (@(posedge clk) disable iff (rst)
        !(push && (occupancy == FULL) && !retire));

endmodule

// File: tb/tb_mips_wb_stage_buffered.sv
// Directed bench for mips_wb_stage_buffered: stimulus pushes expected retire
// records into a queue, an independent monitor checks each retire in order.
module tb_mips_wb_stage_buffered;

    logic        clk;
    logic        rst;
    logic        mem_valid_ready_go;
    logic        wb_allowin;
    logic [31:0] mem_out_op;
    logic [4:0]  mem_rf_waddr;
    logic [31:0] mem_value;
    logic [31:0] mem_hi_value;
    logic [31:0] mem_lo_value;
    logic [31:0] mem_pc;
    logic [31:0] mem_instruction;
    logic        trace_ready;
    logic        wb_valid;
    logic [3:0]  wb_rf_wen;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic        wb_hi_wen;
    logic [31:0] wb_hi_value;
    logic        wb_lo_wen;
    logic [31:0] wb_lo_value;
    logic [31:0] wb_pc;
    logic [31:0] wb_instruction;
    logic [31:0] wb_out_op;
    logic [31:0] wb_retire_cnt;

    mips_wb_stage_buffered dut (
        .clk(clk), .rst(rst),
        .mem_valid_ready_go(mem_valid_ready_go), .wb_allowin(wb_allowin),
        .mem_out_op(mem_out_op), .mem_rf_waddr(mem_rf_waddr),
        .mem_value(mem_value), .mem_hi_value(mem_hi_value),
        .mem_lo_value(mem_lo_value), .mem_pc(mem_pc),
        .mem_instruction(mem_instruction), .trace_ready(trace_ready),
        .wb_valid(wb_valid), .wb_rf_wen(wb_rf_wen), .wb_rf_waddr(wb_rf_waddr),
        .wb_rf_wdata(wb_rf_wdata), .wb_hi_wen(wb_hi_wen), .wb_hi_value(wb_hi_value),
        .wb_lo_wen(wb_lo_wen), .wb_lo_value(wb_lo_value), .wb_pc(wb_pc),
        .wb_instruction(wb_instruction), .wb_out_op(wb_out_op),
        .wb_retire_cnt(wb_retire_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [3:0]  wen;
        logic        hi_wen;
        logic        lo_wen;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   push_idx = 0;

    localparam logic [31:0] RW = 32'h0000_8000;
    localparam logic [31:0] HI = 32'h0010_0000;
    localparam logic [31:0] LO = 32'h0020_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every retire must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid && trace_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire_pc", wb_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("retire_pc",     wb_pc,              e.pc);
                chk("retire_wdata",  wb_rf_wdata,        e.wdata);
                chk("retire_wen",    32'(wb_rf_wen),     32'(e.wen));
                chk("retire_hi_wen", 32'(wb_hi_wen),     32'(e.hi_wen));
                chk("retire_lo_wen", 32'(wb_lo_wen),     32'(e.lo_wen));
                chk("retire_hi",     wb_hi_value,        e.hi);
                chk("retire_lo",     wb_lo_value,        e.lo);
                chk("retire_cnt",    wb_retire_cnt,      e.cnt);
            end
        end else if (!rst && wb_valid) begin
            chk("stall_strobes", {29'd0, wb_rf_wen == 4'd0 ? 1'b0 : 1'b1, wb_hi_wen, wb_lo_wen}, 32'd0);
        end
    end

    // ---------------- driver ----------------
    // Called one step after a rising edge; returns one step after the accepting edge.
    task automatic push(input logic [31:0] op, input logic [4:0] wa, input logic [31:0] val,
                        input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] pc,
                        input logic [3:0] ewen, input logic ehi, input logic elo);
        bit accepted;
        accepted = 0;
        mem_valid_ready_go = 1'b1;
        mem_out_op = op; mem_rf_waddr = wa; mem_value = val;
        mem_hi_value = hi; mem_lo_value = lo; mem_pc = pc; mem_instruction = ~pc;
        for (int n = 0; n < 20 && !accepted; n++) begin
            @(negedge clk);
            if (wb_allowin) begin
                accepted = 1;
                exp_q.push_back('{pc: pc, wdata: val, wen: ewen, hi_wen: ehi, lo_wen: elo,
                                  hi: hi, lo: lo, cnt: push_idx});
                push_idx++;
            end
        end
        if (!accepted) chk("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        mem_valid_ready_go = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        trace_ready = 1'b1;
        mem_valid_ready_go = 1'b0;
        mem_out_op = '0; mem_rf_waddr = '0; mem_value = '0; mem_hi_value = '0;
        mem_lo_value = '0; mem_pc = '0; mem_instruction = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        chk("reset_valid",   32'(wb_valid),   32'd0);
        chk("reset_allowin", 32'(wb_allowin), 32'd1);
        chk("reset_wen",     32'(wb_rf_wen),  32'd0);
        chk("reset_cnt",     wb_retire_cnt,   32'd0);
        chk("reset_pc",      wb_pc,           32'd0);

        // Full-word write via empty byte-enable field.
        push(RW, 5'd5, 32'hDEADBEEF, 32'd0, 32'd0, 32'h10, 4'b1111, 1'b0, 1'b0);
        idle(1);
        chk("cnt_after_first", wb_retire_cnt, 32'd1);

        // r0 suppression, then a halfword-lane write.
        push(RW | 32'h0003_0000, 5'd0, 32'h1111_2222, 32'd0, 32'd0, 32'h20, 4'b0000, 1'b0, 1'b0);
        push(RW | 32'h0003_0000, 5'd7, 32'h3333_4444, 32'd0, 32'd0, 32'h24, 4'b0011, 1'b0, 1'b0);
        idle(2);

        // Stall until full, then retire and push in the same cycle.
        trace_ready = 1'b0;
        push(RW, 5'd3, 32'hA100, 32'd0, 32'd0, 32'h100, 4'b1111, 1'b0, 1'b0);
        push(RW, 5'd3, 32'hA104, 32'd0, 32'd0, 32'h104, 4'b1111, 1'b0, 1'b0);
        chk("full_allowin", 32'(wb_allowin), 32'd0);
        chk("full_valid",   32'(wb_valid),   32'd1);
        chk("stall_pc",     wb_pc,           32'h100);
        idle(2);
        chk("stall_pc_held", wb_pc,          32'h100);
        chk("stall_wdata",   wb_rf_wdata,    32'hA100);
        chk("stall_cnt",     wb_retire_cnt,  32'd3);
        trace_ready = 1'b1;
        push(RW, 5'd3, 32'hA108, 32'd0, 32'd0, 32'h108, 4'b1111, 1'b0, 1'b0);
        idle(3);

        // HI/LO strobes.
        push(HI | LO, 5'd9, 32'h55, 32'h1, 32'h2, 32'h200, 4'b0000, 1'b1, 1'b1);
        idle(2);
        chk("hilo_cnt", wb_retire_cnt, 32'd7);

        // Asynchronous reset with two entries in flight.
        trace_ready = 1'b0;
        push(RW, 5'd4, 32'hB000, 32'd0, 32'd0, 32'h300, 4'b1111, 1'b0, 1'b0);
        push(RW, 5'd4, 32'hB004, 32'd0, 32'd0, 32'h304, 4'b1111, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid",   32'(wb_valid),   32'd0);
        chk("async_rst_cnt",     wb_retire_cnt,   32'd0);
        chk("async_rst_pc",      wb_pc,           32'd0);
        chk("async_rst_allowin", 32'(wb_allowin), 32'd1);
        exp_q.delete();
        push_idx = 0;
        @(negedge clk);
        rst = 1'b0;
        trace_ready = 1'b1;
        idle(1);
        push(RW, 5'd6, 32'hC0DE, 32'd0, 32'd0, 32'h400, 4'b1111, 1'b0, 1'b0);
        idle(1);
        chk("post_rst_cnt", wb_retire_cnt, 32'd1);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) idle(1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_wb_stage_buffered.md
Name: mips_wb_stage_buffered

Overview:
Parametrised writeback stage for the five-stage MIPS pipeline. It takes results from the memory stage through the valid/ready_go and allowin handshake, and holds them in a DEPTH-entry in-order queue. An instruction retires from the queue head only when the downstream retire/trace consumer accepts it. At retire it drives byte-lane register-file writes, separate HI/LO write enables, and a retired-instruction counter.

Parameters:
DATA_W, 32, width of result, HI/LO, PC and instruction words
OP_W, 32, width of the control-op bundle
RW_BIT, 15, op bit for the register-write request
BE_LSB, 16, LSB of the 4-bit byte-enable field op[BE_LSB+3:BE_LSB]
HI_WE_BIT, 20, op bit for the HI write request
LO_WE_BIT, 21, op bit for the LO write request
DEPTH, 2, queue entries; power of two, at least 2
CNT_W, 32, width of the retire counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-high reset
mem_valid_ready_go  in  1  memory stage offers an instruction
wb_allowin  out  1  this stage can accept an instruction this cycle
mem_out_op  in  OP_W  control bundle
mem_rf_waddr  in  5  destination register
mem_value  in  DATA_W  result
mem_hi_value  in  DATA_W  HI result
mem_lo_value  in  DATA_W  LO result
mem_pc  in  DATA_W  PC
mem_instruction  in  DATA_W  instruction word
trace_ready  in  1  retire consumer accepts the head entry
wb_valid  out  1  queue head is valid
wb_rf_wen  out  4  byte write enables to the register file
wb_rf_waddr  out  5  head destination register
wb_rf_wdata  out  DATA_W  head result
wb_hi_wen  out  1  HI write strobe
wb_hi_value  out  DATA_W  head HI value
wb_lo_wen  out  1  LO write strobe
wb_lo_value  out  DATA_W  head LO value
wb_pc  out  DATA_W  head PC
wb_instruction  out  DATA_W  head instruction
wb_out_op  out  OP_W  head op bundle
wb_retire_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Reset (asynchronous, active-high), applied at any time including mid-operation:
  - read and write pointers, occupancy and wb_retire_cnt go to 0
  - every entry's data is cleared, so all data outputs read 0
  - wb_valid=0, all write strobes 0, wb_allowin=1
  - in-flight entries are discarded
- Handshakes:
  - push = mem_valid_ready_go & wb_allowin
  - retire = wb_valid & trace_ready
  - wb_allowin = (occupancy < DEPTH) | retire. This is combinational from trace_ready, so a full queue accepts a push in the same cycle it retires.
- Latency:
  - an entry pushed at edge N is visible at the head, with wb_valid=1, after edge N when the queue was empty
  - there is no combinational bypass from mem_* to wb_*
- Ordering: strict FIFO. Simultaneous push and retire leaves occupancy unchanged and advances both pointers. Pointers wrap modulo DEPTH.
- wb_valid = (occupancy != 0).
- Head outputs:
  - data outputs always reflect the entry at the read pointer
  - when empty they show that stale slot, which is 0 after reset
  - consumers must qualify on wb_valid
- Write strobes are asserted only in a retire cycle:
  - be = head op[BE_LSB+3:BE_LSB]; if be==4'b0000, treat it as 4'b1111 for full-word compatibility
  - wb_rf_wen = {4{retire & op[RW_BIT] & (wb_rf_waddr!=0)}} & be
  - wb_hi_wen = retire & op[HI_WE_BIT]; wb_lo_wen = retire & op[LO_WE_BIT]
- Stall: with trace_ready=0, the head and all head outputs hold stable and no strobes are raised. Once the queue is full, wb_allowin=0.
- wb_retire_cnt increments by 1 on every retire and wraps modulo 2^CNT_W.
- The occupancy counter is $clog2(DEPTH)+1 bits wide and never exceeds DEPTH. A push while full without a retire is impossible by construction; an assertion must flag it.

Test Plan:
- Reset then idle, trace_ready=1 -> wb_valid=0, wb_allowin=1, wb_rf_wen=0, wb_retire_cnt=0.
- Push op with bit15=1, be=0, waddr=5, value=0xDEADBEEF, trace_ready=1 -> next cycle wb_valid=1, wb_rf_wen=4'b1111, wb_rf_wdata=0xDEADBEEF, wb_retire_cnt 0->1.
- Push be=4'b0011 to waddr=0, then be=4'b0011 to waddr=7 -> first retire wb_rf_wen=0 (r0 suppressed), second wb_rf_wen=4'b0011.
- trace_ready=0, push PCs 0x100, 0x104 (DEPTH=2) -> wb_allowin=0 after second push, wb_pc=0x100 held, no strobes. Raise trace_ready together with a push of 0x108 -> 0x100 retires, 0x108 is accepted the same cycle, retire order 0x100, 0x104, 0x108.
- Op with HI_WE and LO_WE bits set, hi=0x1, lo=0x2 -> wb_hi_wen=wb_lo_wen=1 for exactly the retire cycle, wb_hi_value=0x1, wb_lo_value=0x2.
- Assert rst asynchronously between edges with 2 entries queued -> wb_valid falls immediately, wb_retire_cnt=0. After release, the first new push retires correctly with counter 0->1.
